// File: rtl/serial_nor_adder.sv
// Bit-serial adder: sequences two WIDTH-bit operands LSB-first through two
// cascaded NOR-only half-adder stages and a carry register, with valid/ready on both sides.
module serial_nor_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [1:0]       ha1, ha2;
    logic             carry_next;
    logic [WIDTH-1:0] acc_shift;

    function automatic logic nor2(input logic x, input logic y);
        return ~(x | y);
    endfunction

    // Half adder built only from NOR gates; returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        logic n1, n2, n3, xn, s, c;
        n1 = nor2(x, y);
        n2 = nor2(x, n1);
        n3 = nor2(y, n1);
        xn = nor2(n2, n3);
        s  = nor2(xn, xn);
        c  = nor2(nor2(x, x), nor2(y, y));
        return {c, s};
    endfunction

    always_comb begin
        ha1        = half_add(a_q[0], b_q[0]);
        ha2        = half_add(ha1[0], c_q);
        carry_next = ha1[1] | ha2[1];
        acc_shift  = (acc_q >> 1) | (WIDTH'(ha2[0]) << (WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = carry_next;
                acc_d = acc_shift;
                cnt_d = cnt_q + CNT_W'(1);
                // Output registers only update on the last bit, so sum/cout stay stable mid-operation.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = acc_shift;
                    cout_d  = carry_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_nor_adder.sv
// Directed bench for serial_nor_adder: an 8-bit instance for handshake, backpressure
// and reset behaviour, and a 1-bit instance for the full-adder truth table.
module tb_serial_nor_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid8 = 1'b0, out_ready8 = 1'b1, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       in_ready8, out_valid8, cout8, busy8;
    logic [7:0] sum8;

    logic       in_valid1 = 1'b0, out_ready1 = 1'b1, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       in_ready1, out_valid1, cout1, busy1;
    logic [0:0] sum1;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    serial_nor_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .busy(busy8)
    );

    serial_nor_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepts one operand set on dut8 and returns the number of edges from accept to out_valid.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv, output int edges);
        a8 = av; b8 = bv; cin8 = cv; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        edges = 0;
        while (!out_valid8 && edges < 40) begin
            step();
            edges++;
        end
    endtask

    task automatic op1(input logic av, input logic bv, input logic cv, output int edges);
        a1 = av; b1 = bv; cin1 = cv; in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        edges = 0;
        while (!out_valid1 && edges < 40) begin
            step();
            edges++;
        end
    endtask

    initial begin
        logic [7:0] exp_s1;
        logic [7:0] exp_c1;
        logic [2:0] v;

        // Reset values while rst_n is low
        #2;
        chk("rst_in_ready", in_ready8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_out_valid", out_valid8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // 0x5A + 0x3C
        op8(8'h5A, 8'h3C, 1'b0, n);
        chk("lat_5a3c", n, 8);
        chk("sum_5a3c", sum8, 8'h96);
        chk("cout_5a3c", cout8, 0);
        chk("inrdy_done", in_ready8, 0);
        chk("busy_done", busy8, 1);
        step();
        chk("handoff_ovalid", out_valid8, 0);
        chk("handoff_inrdy", in_ready8, 1);
        chk("hold_sum_idle", sum8, 8'h96);

        // 0xFF + 0x01 with backpressure
        out_ready8 = 1'b0;
        op8(8'hFF, 8'h01, 1'b0, n);
        chk("lat_ff01", n, 8);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ovalid", out_valid8, 1);
            chk("bp_sum", sum8, 8'h00);
            chk("bp_cout", cout8, 1);
            chk("bp_inrdy", in_ready8, 0);
        end
        out_ready8 = 1'b1;
        step();
        chk("bp_release_ovalid", out_valid8, 0);
        chk("bp_release_inrdy", in_ready8, 1);

        // 0xFF + 0xFF + 1
        op8(8'hFF, 8'hFF, 1'b1, n);
        chk("lat_ffff", n, 8);
        chk("sum_ffff", sum8, 8'hFF);
        chk("cout_ffff", cout8, 1);
        step();

        // Busy rejection: second operand pair offered during SHIFT
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; in_valid8 = 1'b1;
        step();
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
        n = 0;
        while (!out_valid8 && n < 40) begin
            step();
            n++;
        end
        in_valid8 = 1'b0;
        chk("lat_busy", n, 8);
        chk("sum_busy", sum8, 8'h30);
        chk("cout_busy", cout8, 0);
        step();
        chk("busy_after_handoff", busy8, 0);
        step();
        chk("busy_not_consumed", busy8, 0);
        chk("inrdy_not_consumed", in_ready8, 1);

        // Reset after the 3rd SHIFT edge
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        step(); step(); step();
        chk("pre_rst_busy", busy8, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inrdy", in_ready8, 1);
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_ovalid", out_valid8, 0);
        chk("mid_rst_sum", sum8, 0);
        chk("mid_rst_cout", cout8, 0);
        step();
        #2;
        rst_n = 1'b1;
        step();
        op8(8'h01, 8'h01, 1'b1, n);
        chk("lat_post_rst", n, 8);
        chk("sum_post_rst", sum8, 8'h03);
        chk("cout_post_rst", cout8, 0);
        step();

        // WIDTH=1 full-adder truth table; index bit0=a, bit1=b, bit2=cin
        exp_s1 = 8'b1001_0110;
        exp_c1 = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            op1(v[0], v[1], v[2], n);
            chk("w1_lat", n, 1);
            chk("w1_sum", sum1, exp_s1[i]);
            chk("w1_cout", cout1, exp_c1[i]);
            step();
            chk("w1_inrdy", in_ready1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
